ble_auth_rx: RTL
================

BLE_AUTH_RX -- requirements
Module: ble_auth_rx

Interface
REQ-001 Parameter BAUD_DIV, default 2604, clocks per UART bit (50 MHz / 19200 baud); legal range 8..4095.
REQ-002 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 RX  input  1  asynchronous serial line from BLE module; 8N1, LSB first, idle high.
REQ-005 rider_off  input  1  high when load cells report no rider.
REQ-006 rx_data  output  8  last correctly framed byte.
REQ-007 rx_rdy  output  1  one-cycle pulse when rx_data updates.
REQ-008 frm_err  output  1  one-cycle pulse on stop-bit error.
REQ-009 pwr_up  output  1  high when the Segway is authorized to balance.

Function
REQ-010 RX SHALL pass through a two-flop synchronizer, plus one history flop for edge detect; the synchronizer flops SHALL reset to 1.
REQ-011 Receiver FSM states: IDLE, START, DATA, STOP.
REQ-012 IDLE -> START on a synchronized falling edge; the baud counter loads BAUD_DIV/2, integer floor.
REQ-013 START: at counter expiry, sample RX.
  - Sample 0 -> DATA; counter loads BAUD_DIV.
  - Sample 1 (glitch) -> IDLE with no output.
REQ-014 DATA: sample at each counter expiry (mid-bit) and shift into bit 7 of a 9-bit shift register, right-shifting; bit counter 0..7.
  - After the 8th sample -> STOP; counter reloads BAUD_DIV.
REQ-015 STOP: sample at expiry.
  - Sample 1: rx_data <= byte and rx_rdy pulses for exactly one cycle, starting the cycle after the sample.
  - Sample 0: rx_data is unchanged and frm_err pulses for one cycle instead.
  - Either case -> IDLE.
REQ-016 IDLE SHALL NOT detect a new start until the synchronized RX has been seen high for at least one cycle, so a held-low line does not retrigger.
REQ-017 Back-to-back bytes with a one-bit-time stop gap SHALL all be received without loss.
REQ-018 Auth FSM states: OFF, PWR1, PWR2. It acts only on cycles where rx_rdy=1 or rider_off changes level. Its outputs are registered and take effect the cycle after the rx_rdy pulse.
REQ-019 OFF: byte 0x67 ('g') -> PWR1; all other bytes are ignored; rider_off has no effect.
REQ-020 PWR1 ('g' received, rider on):
  - byte 0x73 ('s') with rider_off=1 -> OFF.
  - byte 0x73 ('s') with rider_off=0 -> PWR2.
  - rider_off alone -> stays PWR1.
  - Other bytes are ignored.
REQ-021 PWR2 (stop requested, rider still on):
  - rider_off=1 -> OFF.
  - byte 'g' -> PWR1.
  - Other bytes are ignored.
REQ-022 If 'g' and rider_off=1 occur in the same PWR2 cycle, 'g' SHALL win (-> PWR1).
REQ-023 pwr_up SHALL be 1 in PWR1 and PWR2, and 0 in OFF, registered.
REQ-024 A byte flagged by frm_err SHALL never influence the auth FSM.

Reset
REQ-025 When rst=1 at a clock edge, the following SHALL hold the next cycle:
  - receiver FSM = IDLE, auth FSM = OFF;
  - rx_data = 8'h00, rx_rdy = 0, frm_err = 0, pwr_up = 0;
  - counters cleared.
REQ-026 Reset asserted mid-byte SHALL abort the byte with no rx_rdy or frm_err.
  - After rst deasserts, a falling edge SHALL be required before reception restarts; a remaining low data bit does start a new (possibly bad) frame.
REQ-027 Reset SHALL override all other inputs on the same cycle.

Verification (bench uses BAUD_DIV=16)
REQ-028 Send 0x67 with rider_off=0:
  - rx_data=0x67;
  - rx_rdy pulses once, 1 cycle wide, 152+/-2 clocks after the start edge;
  - pwr_up rises one cycle after rx_rdy.
REQ-029 Starting in PWR1, rider_off=1, send 0x73: pwr_up falls to 0 (OFF).
  - Repeat with rider_off=0: pwr_up stays 1 (PWR2).
  - Then raise rider_off: pwr_up falls the next cycle.
REQ-030 Send 0x55 with the stop bit forced to 0:
  - frm_err pulses once, no rx_rdy;
  - rx_data keeps its prior value;
  - auth state unchanged.
REQ-031 Drive a 4-clock low glitch on RX while IDLE: no rx_rdy, no frm_err; a following 0xA5 is received correctly.
REQ-032 Send three back-to-back bytes 0x00, 0xFF, 0x67 with no idle gap: three rx_rdy pulses, in order, and pwr_up=1 at the end.
REQ-033 Assert rst for 1 cycle during data bit 4 of 0x67 while in OFF:
  - all outputs return to their reset values;
  - no rx_rdy for the aborted byte;
  - pwr_up stays 0.

Source files
------------

// File: rtl/ble_auth_rx_if.sv
// rtl/ble_auth_rx_if.sv - serial line, rider sense and receive/authorization outputs of ble_auth_rx
interface ble_auth_rx_if;
  logic       RX;
  logic       rider_off;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frm_err;
  logic       pwr_up;

  modport master (
    output RX,
    output rider_off,
    input  rx_data,
    input  rx_rdy,
    input  frm_err,
    input  pwr_up
  );

  modport slave (
    input  RX,
    input  rider_off,
    output rx_data,
    output rx_rdy,
    output frm_err,
    output pwr_up
  );
endinterface

// File: rtl/ble_auth_rx.sv
// rtl/ble_auth_rx.sv - 8N1 UART receiver feeding the 'g'/'s' balance authorization FSM
module ble_auth_rx #(
  parameter int BAUD_DIV = 2604
) (
  input logic        clk,
  input logic        rst,
  ble_auth_rx_if.slave bus
);

  localparam logic [11:0] BAUD_FULL = 12'(BAUD_DIV);
  localparam logic [11:0] BAUD_HALF = 12'(BAUD_DIV / 2);
  localparam logic [7:0]  CHAR_G    = 8'h67;
  localparam logic [7:0]  CHAR_S    = 8'h73;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    AUTH_OFF,
    AUTH_PWR1,
    AUTH_PWR2
  } auth_state_t;

  rx_state_t   rx_state, rx_next;
  auth_state_t auth_state, auth_next;

  logic        rx_s1, rx_s2, rx_hist;
  logic        rx_fall;
  logic [11:0] baud_cnt;
  logic        baud_exp;
  logic [2:0]  bit_cnt;
  logic [8:0]  shreg;
  logic [7:0]  rx_data_q;
  logic        rx_rdy_q;
  logic        frm_err_q;
  logic        pwr_up_q;
  logic        rider_q;

  logic        load_half;
  logic        load_full;
  logic        shift_en;
  logic        stop_ok;
  logic        stop_bad;

  // Synchronizer and history flops idle high so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_hist <= 1'b1;
    end else begin
      rx_s1   <= bus.RX;
      rx_s2   <= rx_s1;
      rx_hist <= rx_s2;
    end
  end

  // A start needs the line seen high first, so a held-low line cannot retrigger.
  assign rx_fall  = rx_hist & ~rx_s2;
  // Expiry one count before zero keeps each bit period exactly the loaded value.
  assign baud_exp = (baud_cnt == 12'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
    end else begin
      rx_state <= rx_next;
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) rx_next = RX_START;
      end
      RX_START: begin
        if (baud_exp) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (baud_exp && (bit_cnt == 3'd7)) rx_next = RX_STOP;
      end
      RX_STOP: begin
        if (baud_exp) rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (rx_state)
      RX_IDLE:  load_half = rx_fall;
      RX_START: load_full = baud_exp & ~rx_s2;
      RX_DATA: begin
        shift_en  = baud_exp;
        load_full = baud_exp;
      end
      RX_STOP: begin
        stop_ok  = baud_exp & rx_s2;
        stop_bad = baud_exp & ~rx_s2;
      end
      default: begin
        load_half = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt  <= 12'd0;
      bit_cnt   <= 3'd0;
      shreg     <= 9'd0;
      rx_data_q <= 8'h00;
      rx_rdy_q  <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      rx_rdy_q  <= stop_ok;
      frm_err_q <= stop_bad;

      if (load_half) begin
        baud_cnt <= BAUD_HALF;
      end else if (load_full) begin
        baud_cnt <= BAUD_FULL;
      end else if (rx_state == RX_IDLE) begin
        baud_cnt <= 12'd0;
      end else if (baud_cnt != 12'd0) begin
        baud_cnt <= baud_cnt - 12'd1;
      end

      if (rx_state != RX_DATA) begin
        bit_cnt <= 3'd0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      // LSB arrives first, so right-shifting into bit 7 leaves the byte in [7:0].
      if (shift_en) begin
        shreg <= {shreg[8], rx_s2, shreg[7:1]};
      end else if (stop_ok || stop_bad) begin
        shreg[8] <= rx_s2;
      end

      if (stop_ok) begin
        rx_data_q <= shreg[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      auth_state <= AUTH_OFF;
      pwr_up_q   <= 1'b0;
      rider_q    <= 1'b0;
    end else begin
      auth_state <= auth_next;
      pwr_up_q   <= (auth_next != AUTH_OFF);
      rider_q    <= bus.rider_off;
    end
  end

  // Only good bytes reach rx_rdy_q, so framing errors never move this FSM.
  always_comb begin
    auth_next = auth_state;
    if (rx_rdy_q || (bus.rider_off != rider_q)) begin
      case (auth_state)
        AUTH_OFF: begin
          if (rx_rdy_q && (rx_data_q == CHAR_G)) auth_next = AUTH_PWR1;
        end
        AUTH_PWR1: begin
          if (rx_rdy_q && (rx_data_q == CHAR_S)) begin
            auth_next = bus.rider_off ? AUTH_OFF : AUTH_PWR2;
          end
        end
        AUTH_PWR2: begin
          if (rx_rdy_q && (rx_data_q == CHAR_G)) begin
            auth_next = AUTH_PWR1;
          end else if (bus.rider_off) begin
            auth_next = AUTH_OFF;
          end
        end
        default: auth_next = AUTH_OFF;
      endcase
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.rx_rdy  = rx_rdy_q;
  assign bus.frm_err = frm_err_q;
  assign bus.pwr_up  = pwr_up_q;

endmodule
